// File: rtl/hid_event_sequencer.sv
// hid_event_sequencer: turns two-byte MCU commands into CH446Q-style serial
// key writes (DAT/SK/STB) and parallel mouse register strobes (DI + MX/MY/MKEY).
// Commands are assembled, queued in a small first-word-fall-through FIFO, then
// played out by the sequencer one at a time.
module hid_event_sequencer #(
    parameter int HALF  = 4,
    parameter int DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       DAT,
    output logic       SK,
    output logic       STB,
    output logic       MX,
    output logic       MY,
    output logic       MKEY,
    output logic [7:0] DI,
    output logic       busy,
    output logic       err
);
    localparam int         CW      = $clog2(DEPTH + 1);
    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] PH_INIT = 8'(HALF - 1);

    typedef enum logic {WANT_OP, WANT_PL} asm_t;
    typedef enum logic [2:0] {
        IDLE, KBIT, KSTB_SETUP, KSTB_HI, KSTB_LO, M_SETUP, M_HI, M_LO
    } seq_t;

    // ---------------- command assembler ----------------
    asm_t       asm_q, asm_n;
    logic [2:0] op_q, op_n;
    logic       op_ok_q, op_ok_n;
    logic       err_n;
    logic       accept, push, pop;
    logic       full, empty;

    assign accept   = in_valid && in_ready;
    assign push     = accept && (asm_q == WANT_PL) && op_ok_q;
    // Only a payload can stall, and a pop in the same cycle frees its slot.
    assign in_ready = (asm_q == WANT_OP) || !full || pop;

    // Assembler state register; err is registered so it is a clean one-cycle pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            asm_q   <= WANT_OP;
            op_q    <= '0;
            op_ok_q <= 1'b0;
            err     <= 1'b0;
        end else begin
            asm_q   <= asm_n;
            op_q    <= op_n;
            op_ok_q <= op_ok_n;
            err     <= err_n;
        end
    end

    // Opcode/payload pairing, stray-byte and bad-opcode rejection.
    always_comb begin
        asm_n   = asm_q;
        op_n    = op_q;
        op_ok_n = op_ok_q;
        err_n   = 1'b0;
        if (accept) begin
            if (asm_q == WANT_OP) begin
                if (!in_data[7]) begin
                    err_n = 1'b1;
                end else begin
                    asm_n   = WANT_PL;
                    op_n    = in_data[2:0];
                    op_ok_n = (in_data >= 8'h81) && (in_data <= 8'h84);
                end
            end else begin
                asm_n = WANT_OP;
                err_n = !op_ok_q;
            end
        end
    end

    // ---------------- command FIFO ----------------
    logic [10:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic [10:0]   head;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign head  = mem[rd_ptr];

    // Storage array; entry is {opcode[2:0], payload}.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= {op_q, in_data};
    end

    // Pointers and occupancy; push+pop together leaves the count unchanged.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // ---------------- output sequencer ----------------
    seq_t        st_q, st_n;
    logic [7:0]  ph_q, ph_n;
    logic [2:0]  bit_q, bit_n;
    logic        skh_q, skh_n;
    logic [10:0] cmd_q, cmd_n;
    logic [7:0]  di_q, di_n;
    logic        ph_done;

    assign ph_done = (ph_q == 8'd0);

    // Sequencer state register; DI idles high until the first mouse write.
    always_ff @(posedge CLK) begin
        if (RST) begin
            st_q  <= IDLE;
            ph_q  <= PH_INIT;
            bit_q <= '0;
            skh_q <= 1'b0;
            cmd_q <= '0;
            di_q  <= 8'hFF;
        end else begin
            st_q  <= st_n;
            ph_q  <= ph_n;
            bit_q <= bit_n;
            skh_q <= skh_n;
            cmd_q <= cmd_n;
            di_q  <= di_n;
        end
    end

    // Next-state: every non-idle phase lasts HALF cycles, counted down to 0.
    always_comb begin
        st_n  = st_q;
        bit_n = bit_q;
        skh_n = skh_q;
        cmd_n = cmd_q;
        di_n  = di_q;
        pop   = 1'b0;
        ph_n  = (st_q == IDLE || ph_done) ? PH_INIT : ph_q - 8'd1;
        case (st_q)
            IDLE: begin
                if (!empty) begin
                    pop   = 1'b1;
                    cmd_n = head;
                    bit_n = 3'd6;
                    skh_n = 1'b0;
                    if (head[10:8] == 3'b001) begin
                        st_n = KBIT;
                    end else begin
                        st_n = M_SETUP;
                        di_n = head[7:0];
                    end
                end
            end
            KBIT: begin
                if (ph_done) begin
                    if (!skh_q) begin
                        skh_n = 1'b1;
                    end else begin
                        skh_n = 1'b0;
                        if (bit_q == 3'd0) st_n = KSTB_SETUP;
                        else               bit_n = bit_q - 3'd1;
                    end
                end
            end
            KSTB_SETUP: if (ph_done) st_n = KSTB_HI;
            KSTB_HI:    if (ph_done) st_n = KSTB_LO;
            KSTB_LO:    if (ph_done) st_n = IDLE;
            M_SETUP:    if (ph_done) st_n = M_HI;
            M_HI:       if (ph_done) st_n = M_LO;
            M_LO:       if (ph_done) st_n = IDLE;
            default:    st_n = IDLE;
        endcase
    end

    // Outputs decoded from registered state, so strobes are mutually exclusive by construction.
    always_comb begin
        DAT  = 1'b0;
        if (st_q == KBIT) DAT = cmd_q[bit_q];
        else if (st_q == KSTB_SETUP || st_q == KSTB_HI || st_q == KSTB_LO) DAT = cmd_q[7];
        SK   = (st_q == KBIT) && skh_q;
        STB  = (st_q == KSTB_HI);
        MX   = (st_q == M_HI) && (cmd_q[10:8] == 3'b010);
        MY   = (st_q == M_HI) && (cmd_q[10:8] == 3'b011);
        MKEY = (st_q == M_HI) && (cmd_q[10:8] == 3'b100);
        DI   = di_q;
        busy = (st_q != IDLE);
    end
endmodule

// File: doc/hid_event_sequencer.md
HID_EVENT_SEQUENCER -- requirements
Module: hid_event_sequencer

Interface
REQ-001 SHALL have parameter HALF, default 4: clock cycles per half-period of SK and per strobe phase; legal range 1..255.
REQ-002 SHALL have parameter DEPTH, default 4: number of entries in the command FIFO; power of two.
REQ-003 SHALL have port CLK, input, 1 bit: single clock; every register is clocked on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_data, input, 8 bits: command byte from the MCU link.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: a byte is accepted in any cycle where in_valid and in_ready are both 1.
REQ-008 SHALL have ports DAT, SK and STB, outputs, 1 bit each: CH446Q-style serial keyboard link to the downstream bus stage.
REQ-009 SHALL have ports MX, MY and MKEY, outputs, 1 bit each: mouse register write strobes; the downstream stage captures on the rising edge.
REQ-010 SHALL have port DI, output, 8 bits: mouse data bus.
REQ-011 SHALL have port busy, output, 1 bit: the sequencer is not in IDLE.
REQ-012 SHALL have port err, output, 1 bit: one-cycle pulse when a command is rejected.

Function
REQ-013 Command format SHALL be two bytes: opcode byte (bit7=1), then payload byte.
- 0x81: KEY, payload = {state, addr[6:0]}.
- 0x82: MX, payload = X.
- 0x83: MY, payload = Y.
- 0x84: MKEY, payload = buttons.
REQ-014 The assembler SHALL hold state WANT_OP or WANT_PL.
- In WANT_OP, a byte with bit7=0 SHALL be dropped, err SHALL pulse, and the state SHALL not change.
REQ-015 An opcode byte outside 0x81..0x84 with bit7=1 SHALL be accepted and its payload consumed, then the pair SHALL be discarded with one err pulse on payload acceptance; no FIFO write.
REQ-016 On payload acceptance, {opcode[2:0], payload} SHALL be written to the FIFO in the same cycle.
REQ-017 in_ready SHALL be 0 only when the assembler is in WANT_PL and the FIFO is full.
- Opcode bytes and stray bytes are always accepted.
REQ-018 The FIFO SHALL be first-word-fall-through.
- Push and pop in the same cycle while full SHALL both succeed.
- The count SHALL never exceed DEPTH or underflow.
REQ-019 The sequencer states SHALL be IDLE, KBIT, KSTB_SETUP, KSTB_HI, KSTB_LO, M_SETUP, M_HI, M_LO.
- IDLE with FIFO non-empty SHALL pop the FIFO and enter KBIT (KEY) or M_SETUP (mouse) on the next cycle.
REQ-020 KBIT SHALL send addr[6] first, down to addr[0].
- Per bit: DAT = bit and SK = 0 for HALF cycles, then SK = 1 for HALF cycles.
- DAT SHALL be held through the SK-high phase.
- After 7 bits, the next state SHALL be KSTB_SETUP.
REQ-021 KSTB_SETUP SHALL drive DAT = state, SK = 0, STB = 0 for HALF cycles.
- KSTB_HI SHALL drive STB = 1 for HALF cycles.
- KSTB_LO SHALL drive STB = 0 for HALF cycles, then go to IDLE.
- DAT SHALL hold state until KSTB_LO ends.
- A KEY command SHALL occupy exactly 17*HALF cycles, not counting the IDLE pop cycle.
REQ-022 M_SETUP SHALL drive DI = payload for HALF cycles with strobes at 0.
- M_HI SHALL drive the selected strobe (MX/MY/MKEY) = 1 for HALF cycles.
- M_LO SHALL drive all strobes = 0 for HALF cycles, then go to IDLE.
- Total: 3*HALF cycles.
REQ-023 DI SHALL keep its last value until the next mouse command's M_SETUP.
REQ-024 At most one of STB, MX, MY, MKEY SHALL be 1 in any cycle.
- SK and STB SHALL never both be 1.
REQ-025 A single 8-bit phase counter SHALL count HALF-1 down to 0.
- A 3-bit counter SHALL track the bit index.
- No wrap past bit 0 is permitted.
REQ-026 IDLE SHALL hold DAT = 0, SK = 0, STB = 0; busy SHALL be 0 only in IDLE.

Reset
REQ-027 While RST = 1, in the cycle after RST is sampled high, all state SHALL clear:
- assembler to WANT_OP, FIFO emptied, sequencer to IDLE;
- DAT = SK = STB = MX = MY = MKEY = 0, DI = 0xFF, busy = 0, err = 0, in_ready = 1.
REQ-028 Reset mid-command SHALL abort it with no further SK/STB/strobe edges, and any half-assembled opcode SHALL be discarded.

Verification
REQ-029 HALF=4: send 0x81, 0xA4 -> SK rises 7 times with DAT = 0,1,0,0,1,0,0; then DAT = 1, STB high 4 cycles; busy high 68 cycles.
REQ-030 Send 0x82, 0x55 -> DI = 0x55 from the first sequencer cycle; MX high cycles 5..8; MY/MKEY stay 0; busy 12 cycles; DI still 0x55 afterwards.
REQ-031 Send 0x12, then 0x85, 0x00, then 0x84, 0xFE -> two err pulses; only MKEY strobes, with DI = 0xFE.
REQ-032 Hold sequencer busy with a KEY command and push DEPTH+1 further commands -> in_ready drops on the excess payload byte; all commands emerge in order with none lost.
REQ-033 Assert RST during KBIT bit 3 -> next cycle: SK = STB = DAT = 0, DI = 0xFF, busy = 0; a following 0x83, 0x60 executes normally.
REQ-034 Push on the cycle the FIFO pops while full -> count stays DEPTH and the data order is preserved.
